// File: rtl/serial_frame_transmitter_pkg.sv
// Shared definitions for the serial frame transmitter and receiver pair.
// Encodings must stay identical on both ends of the line.
package serial_frame_transmitter_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_frame_transmitter_bit_period_counter.sv
// Free-running bit-period counter: tick marks the last cycle of each bit.
// Held at zero while clear is high so every frame starts on a full period.
module bit_period_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_frame_transmitter.sv
// Parallel-to-serial frame transmitter: start, data LSB first, optional even parity, stop.
// tx is registered from the next state so the line changes on the same edge as the FSM.
module serial_frame_transmitter
  import serial_frame_transmitter_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid,
  output logic                  ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] w_shreg_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_parity;
  logic                  r_tx;
  logic                  r_done;
  logic                  w_tick;
  logic                  w_accept;
  logic                  w_shift;
  logic                  w_tx_nxt;
  logic                  w_ready;
  logic                  w_busy;

  bit_period_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_period_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(r_state == IDLE),
    .tick (w_tick)
  );

  assign w_accept = valid && (r_state == IDLE);
  assign w_shift  = (r_state == DATA) && w_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = START;
      START:   if (w_tick) w_state_nxt = DATA;
      DATA: begin
        if (w_tick && (r_idx == LAST_IDX)) begin
          w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY:  if (w_tick) w_state_nxt = STOP;
      STOP:    if (w_tick) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_shreg_nxt = r_shreg;
    if (w_accept) begin
      w_shreg_nxt = data_in;
    end else if (w_shift) begin
      w_shreg_nxt = r_shreg >> 1;
    end
  end

  // Line level for the cycle after this edge, taken from where the FSM is heading.
  always_comb begin
    w_ready  = (r_state == IDLE);
    w_busy   = (r_state != IDLE);
    w_tx_nxt = LINE_IDLE;
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shreg_nxt[0];
      PARITY:  w_tx_nxt = r_parity;
      default: w_tx_nxt = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg  <= '0;
      r_idx    <= '0;
      r_parity <= 1'b0;
      r_tx     <= LINE_IDLE;
      r_done   <= 1'b0;
    end else begin
      r_shreg <= w_shreg_nxt;
      if (w_accept) begin
        r_idx    <= '0;
        r_parity <= ^data_in;
      end else if (w_shift) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      r_tx   <= w_tx_nxt;
      r_done <= (r_state == STOP) && w_tick;
    end
  end

  assign ready = w_ready;
  assign busy  = w_busy;
  assign tx    = r_tx;
  assign done  = r_done;

endmodule

// File: doc/serial_frame_transmitter.md
# serial_frame_transmitter

Parallel-to-serial frame transmitter for the lab's sequential-logic designs. It accepts one data word on a valid/ready handshake and shifts it out on a single line: a start bit, the data bits LSB first, an optional even-parity bit, then a stop bit. Each bit is held for a fixed number of clock cycles. It is the transmitting end for the team's serial receiver; an idle-high line is the agreed convention between the two.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; must be at least 1.
- `CLKS_PER_BIT`, default 4: clock cycles each bit is held on `tx`; must be at least 1.
- `PARITY_EN`, default 1: 1 inserts an even-parity bit after the data; 0 omits it.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `data_in`  input  DATA_WIDTH  word to send; sampled only on accept.
- `valid`  input  1  `data_in` is presented for transmission.
- `ready`  output  1  high only in IDLE; a word is accepted when `valid` and `ready` are both high at a rising edge.
- `tx`  output  1  serial line, registered; idles at 1.
- `busy`  output  1  high while a frame is in progress (any state except IDLE).
- `done`  output  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx`=1 and `ready`=1.
  - On accept, latch `data_in` into a shift register, clear both counters, go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - `tx` = shift register bit 0 for CLKS_PER_BIT cycles.
  - Then shift right and increment the bit index.
  - After bit DATA_WIDTH-1, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY:
  - `tx` = XOR-reduction of the latched word (even parity), held CLKS_PER_BIT cycles.
  - Then go to STOP.
- STOP:
  - `tx`=1 for CLKS_PER_BIT cycles.
  - Then go to IDLE and assert `done` for exactly that one cycle.
- Bit-period counter:
  - Width `$clog2(CLKS_PER_BIT)`, minimum 1 bit.
  - Counts 0 to CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - With CLKS_PER_BIT=1 every cycle is a bit boundary.
- Bit index: width `$clog2(DATA_WIDTH)`, minimum 1 bit; cleared on accept.
- `valid` while busy is ignored. Nothing is queued, and `data_in` changes have no effect on the frame in progress.
- Reset values:
  - `tx`=1, `ready`=1, `busy`=0, `done`=0.
  - State IDLE; counters and shift register 0.

## Timing
- Accept at edge k: `tx` falls to 0 in the cycle following edge k, and `busy`=1 from that same cycle.
- Frame length is F = (2 + DATA_WIDTH + PARITY_EN) × CLKS_PER_BIT cycles. Defaults give F = 44.
- `done`=1 and `ready`=1 in the cycle after the last stop-bit cycle, which is cycle k+F+1 relative to the accept edge.
- Back-to-back frames:
  - `valid` held high is accepted in that same `done` cycle.
  - The next start bit then begins immediately, leaving 1 idle-high cycle between frames.
- `ready` is combinational from state: no combinational path from `valid` to `ready`.
- Reset mid-frame:
  - At the next edge with `rst`=1, `tx`=1 and the block returns to IDLE.
  - The frame is dropped and `done` is not pulsed.
- `rst` and `valid` both high at the same edge: reset wins and nothing is accepted.

## Structure
- Shared package holds:
  - the state encoding (3-bit localparams IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - the idle line level `LINE_IDLE=1'b1`.
- The receiver uses the same package.
- One sub-module, `bit_period_counter`:
  - parameter CLKS_PER_BIT;
  - inputs `clk`, `rst`, `clear`;
  - output `tick`, high in the last cycle of each bit period.
- The FSM, shift register and bit index stay in the top module.

## Test plan
- Reset then idle: hold `rst` for 3 cycles, then 20 cycles idle → `tx`=1, `ready`=1, `busy`=0, `done`=0 throughout.
- Default frame, 0xA5 accepted:
  - `tx` runs 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles.
  - Parity bit is 0.
  - `done` pulses once, 45 cycles after the accept edge.
- Parity value and no-parity length:
  - With PARITY_EN=1, 0x07 gives parity bit 1 and 0x00 gives parity bit 0.
  - With PARITY_EN=0, frame length is 40 cycles.
- Back-to-back frames: `valid` held high with 0x3C then 0xC3 → second start bit begins 1 cycle after the first `done`; no `valid` lost; `done` pulses exactly twice.
- Ignored `valid` and reset mid-frame:
  - Pulse `valid` with 0xFF during DATA of a 0x00 frame → `tx` data bits stay all 0.
  - Assert `rst` in cycle 20 of a frame → `tx`=1 next cycle, no `done`, and the next accept produces a full clean frame.
- Minimum bit period: CLKS_PER_BIT=1, DATA_WIDTH=1, data 1 → `tx` runs 0,1,1,1 on consecutive cycles, then `done`.
